// File: rtl/tcp_tx_pkg.sv
// Shared types and helpers for the TCP transmit payload path.
// oc_add16 is the 16-bit ones-complement add used for the payload checksum.
package tcp_tx_pkg;

    typedef enum logic [1:0] {S_FILL, S_HELD, S_SEND} state_t;

    localparam int DATA_COUNT_W = 11;

    function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        // Folding the carry back in cannot overflow again: 0xFFFF + 0xFFFF folds to 0xFFFF.
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/tcp_payload_ram.sv
// Simple dual-port DEPTH x 32 payload RAM: one write port, one registered read port.
// Storage is not reset; only the read register clears, so the buffer can present zero data.
module tcp_payload_ram
    import tcp_tx_pkg::*;
#(
    parameter int DEPTH  = 375,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_dat,
    input  logic              i_rd_clr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_dat
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_clr) begin
            o_rd_dat <= '0;
        end else begin
            o_rd_dat <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/tcp_tx_payload_buffer.sv
// Single-frame payload store feeding the TCP frame transmitter; accumulates the ones-complement payload sum.
// Frame is held from commit until the transmitter's busy level falls, then everything clears.
module tcp_tx_payload_buffer
    import tcp_tx_pkg::*;
#(
    parameter int DEPTH  = 375,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [31:0]             i_wr_data,
    input  logic                    i_wr_last,
    output logic                    o_frame_ready,
    output logic [DATA_COUNT_W-1:0] o_data_count,
    output logic [31:0]             o_data,
    input  logic                    i_rd_next,
    input  logic                    i_tx_busy,
    output logic [15:0]             o_payload_sum,
    output logic                    o_truncated
);

    localparam logic [DATA_COUNT_W-1:0] LP_DEPTH = DATA_COUNT_W'(DEPTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_COUNT_W-1:0] r_count;
    logic [ADDR_W-1:0]       r_rd_ptr;
    logic [ADDR_W-1:0]       w_rd_ptr_nxt;
    logic [15:0]             r_sum;
    logic                    r_trunc;
    logic                    r_busy_q;
    logic                    w_wr_acc;
    logic                    w_commit;
    logic                    w_release;
    logic                    w_rd_adv;
    logic                    w_clr;
    logic                    w_busy_rise;
    logic                    w_busy_fall;

    assign w_busy_rise = i_tx_busy & ~r_busy_q;
    assign w_busy_fall = ~i_tx_busy & r_busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_wr_ready    = 1'b0;
        o_frame_ready = 1'b0;
        w_commit      = 1'b0;
        w_release     = 1'b0;
        w_rd_adv      = 1'b0;
        case (r_state)
            S_FILL: begin
                o_wr_ready = (r_count < LP_DEPTH);
                w_commit   = i_wr_valid && o_wr_ready &&
                             (i_wr_last || (r_count == LP_DEPTH - 1'b1));
                if (w_commit) begin
                    w_state_nxt = S_HELD;
                end
            end
            S_HELD: begin
                o_frame_ready = 1'b1;
                if (w_busy_rise) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                o_frame_ready = 1'b1;
                // Pointer saturates on the last committed word.
                w_rd_adv = i_rd_next && ((DATA_COUNT_W'(r_rd_ptr) + 1'b1) < r_count);
                if (w_busy_fall) begin
                    w_state_nxt = S_FILL;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    assign w_wr_acc     = i_wr_valid & o_wr_ready;
    assign w_clr        = ~rst_n | w_release;
    assign w_rd_ptr_nxt = w_clr    ? '0 :
                          w_rd_adv ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_sum    <= '0;
            r_trunc  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_count <= r_count + 1'b1;
                r_sum   <= oc_add16(oc_add16(r_sum, i_wr_data[31:16]), i_wr_data[15:0]);
            end
            if (w_commit && !i_wr_last) begin
                r_trunc <= 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy_q <= 1'b0;
        end else begin
            r_busy_q <= i_tx_busy;
        end
    end

    // Read address is the next pointer so data lands one cycle after rd_next.
    tcp_payload_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_count[ADDR_W-1:0]),
        .i_wr_dat  (i_wr_data),
        .i_rd_clr  (w_clr | (r_state == S_FILL)),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_dat  (o_data)
    );

    assign o_data_count  = r_count;
    assign o_payload_sum = r_sum;
    assign o_truncated   = r_trunc;

endmodule

// File: tb/tb_tcp_tx_payload_buffer.sv
// Randomized self-checking bench for tcp_tx_payload_buffer against a queue-based frame model.
module tb_tcp_tx_payload_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_last = 1'b0;
    logic        rd_next = 1'b0;
    logic        tx_busy = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        frame_ready;
    logic        truncated;
    logic [10:0] data_count;
    logic [31:0] data;
    logic [15:0] payload_sum;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    tcp_tx_payload_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (wr_ready),
        .i_wr_data     (wr_data),
        .i_wr_last     (wr_last),
        .o_frame_ready (frame_ready),
        .o_data_count  (data_count),
        .o_data        (data),
        .i_rd_next     (rd_next),
        .i_tx_busy     (tx_busy),
        .o_payload_sum (payload_sum),
        .o_truncated   (truncated)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sum every 16-bit half as a plain integer, then fold carries back in.
    function automatic logic [15:0] ref_sum();
        longint s = 0;
        foreach (exp_q[i]) s += longint'(exp_q[i][31:16]) + longint'(exp_q[i][15:0]);
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    task automatic wr_word(input logic [31:0] d, input logic last, output logic acc);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        acc      = wr_ready;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic release_frame;
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL reset_frame_ready got=%0d exp=0", frame_ready); end
        checks++; if (data_count !== 11'd0) begin failures++; $display("FAIL reset_data_count got=%0d exp=0", data_count); end
        checks++; if (payload_sum !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", payload_sum); end
        checks++; if (truncated !== 1'b0) begin failures++; $display("FAIL reset_truncated got=%0d exp=0", truncated); end
        checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", data); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0d exp=1", wr_ready); end
    endtask

    task automatic test_basic;
        logic a;
        wr_word(32'h00010002, 1'b0, a);
        wr_word(32'hFFFF0001, 1'b1, a);
        checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL basic_frame_ready got=%0d exp=1", frame_ready); end
        checks++; if (data_count !== 11'd2) begin failures++; $display("FAIL basic_data_count got=%0d exp=2", data_count); end
        checks++; if (payload_sum !== 16'h0004) begin failures++; $display("FAIL basic_sum got=%h exp=0004", payload_sum); end
        checks++; if (truncated !== 1'b0) begin failures++; $display("FAIL basic_truncated got=%0d exp=0", truncated); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL basic_wr_ready_held got=%0d exp=0", wr_ready); end
        tick();
        checks++; if (data !== 32'h00010002) begin failures++; $display("FAIL basic_data0 got=%h exp=00010002", data); end
        rd_next = 1'b1;
        tick();
        rd_next = 1'b0;
        tick();
        checks++; if (data !== 32'h00010002) begin failures++; $display("FAIL held_rd_next_ignored got=%h exp=00010002", data); end
        release_frame();
        checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL release_frame_ready got=%0d exp=0", frame_ready); end
        checks++; if (data_count !== 11'd0) begin failures++; $display("FAIL release_data_count got=%0d exp=0", data_count); end
        checks++; if (payload_sum !== 16'h0) begin failures++; $display("FAIL release_sum got=%h exp=0000", payload_sum); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL release_wr_ready got=%0d exp=1", wr_ready); end
        checks++; if (data !== 32'h0) begin failures++; $display("FAIL release_data got=%h exp=00000000", data); end
    endtask

    task automatic test_random_frames;
        logic a;
        int   n;
        int   idx;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) wr_word($urandom, (i == n - 1), a);
            checks++; if (data_count !== 11'(n)) begin failures++; $display("FAIL rnd_data_count got=%0d exp=%0d", data_count, n); end
            checks++; if (payload_sum !== ref_sum()) begin failures++; $display("FAIL rnd_sum got=%h exp=%h", payload_sum, ref_sum()); end
            checks++; if (truncated !== 1'b0) begin failures++; $display("FAIL rnd_truncated got=%0d exp=0", truncated); end
            checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL rnd_frame_ready got=%0d exp=1", frame_ready); end
            tick();
            tx_busy = 1'b1;
            tick();
            checks++; if (data !== exp_q[0]) begin failures++; $display("FAIL rnd_send_word0 got=%h exp=%h", data, exp_q[0]); end
            // One pulse more than needed to exercise saturation on the last word.
            for (int i = 1; i <= n; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                rd_next = 1'b1;
                tick();
                rd_next = 1'b0;
                idx = (i < n) ? i : n - 1;
                checks++; if (data !== exp_q[idx]) begin failures++; $display("FAIL rnd_send_word%0d got=%h exp=%h", i, data, exp_q[idx]); end
            end
            checks++; if (data_count !== 11'(n)) begin failures++; $display("FAIL rnd_count_stable got=%0d exp=%0d", data_count, n); end
            tx_busy = 1'b0;
            tick();
            exp_q.delete();
            checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL rnd_release_ready got=%0d exp=0", frame_ready); end
            checks++; if (data_count !== 11'd0) begin failures++; $display("FAIL rnd_release_count got=%0d exp=0", data_count); end
            checks++; if (payload_sum !== 16'h0) begin failures++; $display("FAIL rnd_release_sum got=%h exp=0000", payload_sum); end
            checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rnd_release_wr_ready got=%0d exp=1", wr_ready); end
        end
    endtask

    task automatic test_truncate;
        logic       a;
        logic [15:0] s;
        for (int i = 0; i < DEPTH; i++) wr_word($urandom, 1'b0, a);
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL trunc_wr_ready got=%0d exp=0", wr_ready); end
        checks++; if (truncated !== 1'b1) begin failures++; $display("FAIL trunc_flag got=%0d exp=1", truncated); end
        checks++; if (data_count !== 11'(DEPTH)) begin failures++; $display("FAIL trunc_count got=%0d exp=%0d", data_count, DEPTH); end
        checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL trunc_frame_ready got=%0d exp=1", frame_ready); end
        s = ref_sum();
        checks++; if (payload_sum !== s) begin failures++; $display("FAIL trunc_sum got=%h exp=%h", payload_sum, s); end
        wr_word(32'hDEADBEEF, 1'b1, a);
        checks++; if (data_count !== 11'(DEPTH)) begin failures++; $display("FAIL trunc_extra_count got=%0d exp=%0d", data_count, DEPTH); end
        checks++; if (payload_sum !== s) begin failures++; $display("FAIL trunc_extra_sum got=%h exp=%h", payload_sum, s); end
        release_frame();
        checks++; if (truncated !== 1'b0) begin failures++; $display("FAIL trunc_cleared got=%0d exp=0", truncated); end
    endtask

    task automatic test_busy_in_fill;
        logic a;
        wr_word($urandom, 1'b0, a);
        wr_word($urandom, 1'b0, a);
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL fill_busy_frame_ready got=%0d exp=0", frame_ready); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL fill_busy_wr_ready got=%0d exp=1", wr_ready); end
        checks++; if (data_count !== 11'd2) begin failures++; $display("FAIL fill_busy_count got=%0d exp=2", data_count); end
        wr_word($urandom, 1'b1, a);
        checks++; if (data_count !== 11'd3) begin failures++; $display("FAIL fill_busy_count3 got=%0d exp=3", data_count); end
        checks++; if (payload_sum !== ref_sum()) begin failures++; $display("FAIL fill_busy_sum got=%h exp=%h", payload_sum, ref_sum()); end
        tx_busy = 1'b1;
        tick();
        checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL b2b_send_ready got=%0d exp=1", frame_ready); end
        tx_busy = 1'b0;
        tick();
        exp_q.delete();
        checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL b2b_release_ready got=%0d exp=0", frame_ready); end
        checks++; if (data_count !== 11'd0) begin failures++; $display("FAIL b2b_release_count got=%0d exp=0", data_count); end
    endtask

    task automatic test_reset_mid_send;
        logic a;
        for (int i = 0; i < 5; i++) wr_word($urandom, (i == 4), a);
        tick();
        tx_busy = 1'b1;
        tick();
        rd_next = 1'b1;
        tick();
        rd_next = 1'b0;
        checks++; if (data !== exp_q[1]) begin failures++; $display("FAIL rst_send_word1 got=%h exp=%h", data, exp_q[1]); end
        checks++; if (data_count !== 11'd5) begin failures++; $display("FAIL rst_send_count got=%0d exp=5", data_count); end
        rst_n = 1'b0;
        tick();
        checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_frame_ready got=%0d exp=0", frame_ready); end
        checks++; if (data_count !== 11'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", data_count); end
        checks++; if (payload_sum !== 16'h0) begin failures++; $display("FAIL rst_mid_sum got=%h exp=0000", payload_sum); end
        checks++; if (data !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=00000000", data); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_wr_ready got=%0d exp=1", wr_ready); end
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        exp_q.delete();
        wr_word($urandom, 1'b1, a);
        tick();
        checks++; if (data !== exp_q[0]) begin failures++; $display("FAIL rst_next_frame_addr0 got=%h exp=%h", data, exp_q[0]); end
        checks++; if (data_count !== 11'd1) begin failures++; $display("FAIL rst_next_frame_count got=%0d exp=1", data_count); end
        release_frame();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_frames();
        test_truncate();
        test_busy_in_fill();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/tcp_tx_payload_buffer.md
Name: tcp_tx_payload_buffer

Overview:
- Single-frame payload store that sits directly upstream of the TCP/IP frame transmitter.
- Accepts 32-bit payload words from the application and holds one committed frame.
- Supplies the transmitter's `data_count` and `data` inputs and advances a word at a time on its per-word strobe.
- Computes the 16-bit ones-complement payload sum, which the header builder uses for the TCP checksum.
- Releases the frame when the transmitter finishes (its busy signal falls).

Parameters:
- DEPTH, 375, payload capacity in 32-bit words (375 × 4 = 1500 bytes); legal range 1..1024.
- ADDR_W, $clog2(DEPTH), RAM address width; derived, not to be overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- wr_valid  input  1  payload word offered
- wr_ready  output  1  buffer accepts a word this cycle
- wr_data  input  32  payload word, big-endian (bits [31:24] are sent first)
- wr_last  input  1  final word of the frame; qualified by wr_valid & wr_ready
- frame_ready  output  1  a committed frame is held and may be transmitted
- data_count  output  11  committed word count, zero-extended
- data  output  32  word at the read pointer, registered
- rd_next  input  1  one-cycle pulse per consumed word; advances the read pointer
- tx_busy  input  1  transmitter busy level
- payload_sum  output  16  folded ones-complement sum of all payload 16-bit halves
- truncated  output  1  sticky flag: the frame was force-committed at DEPTH

Behaviour:
- Reset, and every return to S_FILL, clears the following:
  - count, rd_ptr, payload_sum, truncated = 0
  - frame_ready = 0, data = 0
  - state = S_FILL
- States:
  - S_FILL: wr_ready = (count < DEPTH). On each accepted word (wr_valid & wr_ready):
    - write mem[count] and increment count;
    - sum = oc_add(oc_add(sum, wr_data[31:16]), wr_data[15:0]), where oc_add is a 17-bit add with end-around carry fold.
    - Commit to S_HELD when the accepted word has wr_last = 1, or when it is word DEPTH-1; in the second case without wr_last, set truncated = 1.
  - S_HELD:
    - frame_ready = 1, wr_ready = 0, rd_ptr = 0.
    - data = mem[0], valid the cycle after entry.
    - A rising edge of tx_busy (registered copy 0, current 1) → S_SEND.
  - S_SEND:
    - frame_ready stays 1 and wr_ready = 0.
    - rd_next at cycle t: rd_ptr increments, saturating at count-1; data shows the new word at t+1 (one-cycle synchronous read latency).
    - A falling edge of tx_busy → S_FILL, with a full clear the same cycle.
- data_count is held stable from S_HELD entry until the release clear.
- Boundary conditions:
  - rd_next in S_FILL or S_HELD is ignored.
  - rd_next at rd_ptr = count-1 is ignored, with no wrap.
  - A tx_busy rising edge in S_FILL is ignored; a zero-word frame never asserts frame_ready.
  - wr_valid while wr_ready = 0 is not accepted, and no state changes.
  - A tx_busy rise and fall in consecutive cycles passes through S_SEND for one cycle, then releases.
  - rst_n low mid-fill or mid-send: the frame is discarded and the clear values appear at the next edge.
  - payload_sum is not complemented; the consumer adds the pseudo-header terms and inverts.

Decomposition:
- Package tcp_tx_pkg:
  - state enum {S_FILL, S_HELD, S_SEND};
  - constant DATA_COUNT_W = 11;
  - function oc_add16(a, b) returning the folded 16-bit sum.
- Sub-module tcp_payload_ram:
  - simple dual-port RAM, DEPTH × 32;
  - one write port, one synchronous read port;
  - no reset on storage.

Test Plan:
- Words 0x00010002, 0xFFFF0001 (wr_last on the second) → frame_ready = 1, data_count = 2, payload_sum = 0x0004, truncated = 0, data = 0x00010002.
- Held frame of 3 words; raise tx_busy, then pulse rd_next twice → data reads word1 then word2, each one cycle after its pulse; a third pulse leaves word2.
- Drop tx_busy after the send → next cycle frame_ready = 0, data_count = 0, payload_sum = 0, wr_ready = 1.
- DEPTH = 4, write 4 words with no wr_last → wr_ready drops after the fourth word, truncated = 1, data_count = 4; a fifth wr_valid is not accepted.
- Assert rst_n = 0 during S_SEND with data_count = 5 → all outputs return to reset values; the next frame writes from address 0.
- tx_busy pulse while in S_FILL with 2 words written → no state change; wr_ready stays 1 and payload_sum keeps accumulating.
